// File: rtl/net_pkg.sv
// Shared types and default sizing for the inference network sequencer.
package net_pkg;

    typedef enum logic [2:0] {IDLE, RUN, WAIT, ARGMAX, DONE} seq_state_t;

    // LOAD_INPUTS, MULTIPLY, SHIFTING, ADD, ACTIVATION_FUNCTION, RESULT, then Y write
    localparam int NEURON_LAT  = 7;
    localparam int DATA_WIDTH  = 8;
    localparam int NUM_CLASSES = 3;

endpackage

// File: rtl/net_sequencer_if.sv
// Host-side handshakes: input vector in, arg-max result out.
interface net_sequencer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_CLASSES = 3
);
    localparam int CLW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    logic                             in_valid;
    logic                             in_ready;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] x_i;
    logic                             out_valid;
    logic                             out_ready;
    logic [CLW-1:0]                   class_o;
    logic [DATA_WIDTH-1:0]            score_o;

    modport master (output in_valid, x_i, out_ready,
                    input  in_ready, out_valid, class_o, score_o);
    modport slave  (input  in_valid, x_i, out_ready,
                    output in_ready, out_valid, class_o, score_o);
endinterface

// File: rtl/net_argmax.sv
// Sequential signed arg-max: one class per cycle while start is held, ties keep the lower index.
module net_argmax #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CLASSES = 3,
    parameter int CLW         = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] y,
    output logic                              done,
    output logic [CLW-1:0]                    cls,
    output logic [DATA_WIDTH-1:0]             score
);
    logic [CLW-1:0]               k_q, best_idx_q, cand_idx;
    logic signed [DATA_WIDTH-1:0] best_q, cand_val, y_k;
    logic                         last;

    assign y_k  = y[k_q*DATA_WIDTH +: DATA_WIDTH];
    assign last = (k_q == CLW'(NUM_CLASSES-1));
    assign done = start && last;

    always_comb begin
        cand_val = best_q;
        cand_idx = best_idx_q;
        if (k_q == '0 || y_k > best_q) begin
            cand_val = y_k;
            cand_idx = k_q;
        end
    end

    // Result registers only update on a completed scan, so an abort keeps the old answer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            cls        <= '0;
            score      <= '0;
        end else if (!start) begin
            k_q <= '0;
        end else begin
            best_q     <= cand_val;
            best_idx_q <= cand_idx;
            k_q        <= last ? '0 : k_q + 1'b1;
            if (last) begin
                cls   <= cand_idx;
                score <= cand_val;
            end
        end
    end
endmodule

// File: rtl/net_sequencer.sv
// Layer sequencer: captures an input vector, pulses Run per layer, waits out neuron latency, scans arg-max.
module net_sequencer #(
    parameter int DATA_WIDTH  = net_pkg::DATA_WIDTH,
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_LAYERS  = 3,
    parameter int NUM_CLASSES = net_pkg::NUM_CLASSES,
    parameter int NEURON_LAT  = net_pkg::NEURON_LAT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    net_sequencer_if.slave                    bus,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]  x_reg_o,
    output logic                              en_o,
    output logic [NUM_LAYERS-1:0]             run_o,
    output logic                              nrn_rst_o,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] y_i,
    input  logic                              abort_i,
    output logic                              busy_o
);
    import net_pkg::*;

    localparam int LW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CNW = $clog2(NEURON_LAT + 1);
    localparam int CLW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    seq_state_t            state_q, state_n;
    logic [LW-1:0]         layer_q, layer_n;
    logic [CNW-1:0]        cnt_q, cnt_n;
    logic [NUM_LAYERS-1:0] run_n;
    logic                  out_valid_q;
    logic                  am_start, am_done;

    assign bus.in_ready  = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign am_start      = (state_q == ARGMAX) && !abort_i;

    always_comb begin
        state_n = state_q;
        layer_n = layer_q;
        cnt_n   = cnt_q;
        run_n   = '0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_n = RUN;
                layer_n = '0;
            end
            RUN: begin
                cnt_n   = CNW'(NEURON_LAT);
                state_n = WAIT;
            end
            WAIT: begin
                cnt_n = cnt_q - 1'b1;
                if (cnt_q == CNW'(1)) begin
                    if (layer_q < LW'(NUM_LAYERS-1)) begin
                        layer_n = layer_q + 1'b1;
                        state_n = RUN;
                    end else begin
                        state_n = ARGMAX;
                    end
                end
            end
            ARGMAX: if (am_done) state_n = DONE;
            DONE:   if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort_i) state_n = IDLE;
        // run_o is registered, so it is decoded from the state being entered
        if (state_n == RUN) run_n[layer_n] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            layer_q     <= '0;
            cnt_q       <= '0;
            x_reg_o     <= '0;
            run_o       <= '0;
            out_valid_q <= 1'b0;
            nrn_rst_o   <= 1'b1;
            en_o        <= 1'b0;
        end else begin
            state_q     <= state_n;
            layer_q     <= layer_n;
            cnt_q       <= cnt_n;
            run_o       <= run_n;
            out_valid_q <= (state_n == DONE);
            nrn_rst_o   <= abort_i;
            en_o        <= !abort_i;
            if (state_q == IDLE && bus.in_valid && !abort_i) x_reg_o <= bus.x_i;
        end
    end

    net_argmax #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CLASSES(NUM_CLASSES),
        .CLW        (CLW)
    ) u_argmax (
        .clk  (clk),
        .rst_n(rst_n),
        .start(am_start),
        .y    (y_i),
        .done (am_done),
        .cls  (bus.class_o),
        .score(bus.score_o)
    );
endmodule
